// File: rtl/fir_mac_param.sv
// fir_mac_param: time-multiplexed FIR dot-product engine.
//   Holds TAPS samples (d) and TAPS weights (w) in serially loaded shift
//   chains. On start it computes sum(d[i]*w[i]) using LANES multipliers over
//   TAPS/LANES passes, through a product / adder-tree / accumulator pipeline,
//   then scales, optionally saturates and presents the result.
// Ports:
//   clk        rising-edge clock
//   rstb       synchronous active-high reset
//   load       shift data into the sample chain (ignored while busy)
//   wind       shift data into the weight chain (ignored while busy)
//   data       serial sample/weight input, DATA_W bits
//   start      request one computation (accepted only when idle)
//   is_signed  operand mode, latched when start is accepted
//   busy       computation in progress
//   out_valid  one-cycle result strobe
//   out        result, OUT_W bits, held until the next result
module fir_mac_param #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 16,
  parameter int LANES  = 4,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0,
  parameter int SAT    = 0
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              load,
  input  logic              wind,
  input  logic [DATA_W-1:0] data,
  input  logic              start,
  input  logic              is_signed,
  output logic              busy,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out
);

  localparam int PASSES = TAPS / LANES;
  localparam int ACC_W  = 2 * DATA_W + $clog2(TAPS);
  localparam int PW     = 2 * DATA_W + 2;
  localparam int GW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int XW     = ACC_W + 1;

  localparam logic [GW-1:0] G_LAST = GW'(PASSES - 1);

  localparam logic signed [XW-1:0] SMAX = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN = {{(XW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [XW-1:0] UMAX = {{(XW-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   g, g_nx;
  logic [1:0]      dcnt, dcnt_nx;
  logic            accept;
  logic            sgn;

  logic [DATA_W-1:0] d [TAPS];
  logic [DATA_W-1:0] w [TAPS];

  logic [DATA_W-1:0]        op_d [LANES];
  logic [DATA_W-1:0]        op_w [LANES];
  logic signed [DATA_W:0]   ea   [LANES];
  logic signed [DATA_W:0]   eb   [LANES];
  logic signed [PW-1:0]     prod_c [LANES];

  logic signed [PW-1:0]     p1 [LANES];
  logic                     v1, f1, l1;

  logic signed [ACC_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  s2;
  logic                     v2, f2, l2;

  logic [ACC_W-1:0]         acc;
  logic                     v3;

  logic signed [XW-1:0]     ext_acc;
  logic signed [XW-1:0]     sh;
  logic [OUT_W-1:0]         res_c;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rstb) begin
      state <= IDLE;
      g     <= '0;
      dcnt  <= '0;
      sgn   <= 1'b0;
    end else begin
      state <= state_nx;
      g     <= g_nx;
      dcnt  <= dcnt_nx;
      if (accept) sgn <= is_signed;
    end
  end

  always_comb begin
    state_nx = state;
    g_nx     = g;
    dcnt_nx  = dcnt;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          g_nx     = '0;
          accept   = 1'b1;
        end
      end
      RUN: begin
        if (g == G_LAST) begin
          state_nx = DRAIN;
          dcnt_nx  = '0;
        end else begin
          g_nx = g + 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt == 2'd2) state_nx = IDLE;
        else              dcnt_nx  = dcnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // ---------------- operand shift chains ----------------
  always_ff @(posedge clk) begin
    if (rstb) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        d[i] <= '0;
        w[i] <= '0;
      end
    end else if (!busy) begin
      if (load) begin
        d[0] <= data;
        for (int unsigned i = 1; i < TAPS; i++) d[i] <= d[i-1];
      end
      if (wind) begin
        w[0] <= data;
        for (int unsigned i = 1; i < TAPS; i++) w[i] <= w[i-1];
      end
    end
  end

  // ---------------- stage 1: lane products ----------------
  // Tap group selected by comparing g against each group index rather than
  // computing g*LANES+lane as an array index.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      op_d[l] = '0;
      op_w[l] = '0;
    end
    for (int unsigned p = 0; p < PASSES; p++) begin
      if (g == GW'(p)) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          op_d[l] = d[p*LANES + l];
          op_w[l] = w[p*LANES + l];
        end
      end
    end
    for (int unsigned l = 0; l < LANES; l++) begin
      ea[l]     = sgn ? {op_d[l][DATA_W-1], op_d[l]} : {1'b0, op_d[l]};
      eb[l]     = sgn ? {op_w[l][DATA_W-1], op_w[l]} : {1'b0, op_w[l]};
      prod_c[l] = ea[l] * eb[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      for (int unsigned l = 0; l < LANES; l++) p1[l] <= '0;
      v1 <= 1'b0;
      f1 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      v1 <= (state == RUN);
      f1 <= (g == '0);
      l1 <= (g == G_LAST);
      if (state == RUN) begin
        for (int unsigned l = 0; l < LANES; l++) p1[l] <= prod_c[l];
      end
    end
  end

  // ---------------- stage 2: adder tree ----------------
  always_comb begin
    sum_c = '0;
    for (int unsigned l = 0; l < LANES; l++) sum_c = sum_c + ACC_W'(p1[l]);
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      s2 <= '0;
      v2 <= 1'b0;
      f2 <= 1'b0;
      l2 <= 1'b0;
    end else begin
      v2 <= v1;
      f2 <= f1;
      l2 <= l1;
      if (v1) s2 <= sum_c;
    end
  end

  // ---------------- stage 3: accumulator ----------------
  always_ff @(posedge clk) begin
    if (rstb) begin
      acc <= '0;
      v3  <= 1'b0;
    end else begin
      v3 <= v2 & l2;
      if (v2) acc <= f2 ? ACC_W'(s2) : acc + ACC_W'(s2);
    end
  end

  // ---------------- output scaling / saturation ----------------
  always_comb begin
    ext_acc = sgn ? {acc[ACC_W-1], acc} : {1'b0, acc};
    sh      = ext_acc >>> SHIFT;
    res_c   = sh[OUT_W-1:0];
    if (SAT != 0) begin
      if (sgn) begin
        if (sh > SMAX)      res_c = SMAX[OUT_W-1:0];
        else if (sh < SMIN) res_c = SMIN[OUT_W-1:0];
      end else if (sh > UMAX) begin
        res_c = UMAX[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v3;
      if (v3) out <= res_c;
    end
  end

endmodule
